// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int          N            = 8;
  localparam int          IDXW         = $clog2(N);
  localparam int unsigned MAX_HOLD_DEF = 16;
  localparam int          HOLD_W       = 16;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set request at or after ptr,
// wrapping 7->0, as one-hot plus encoded index.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    oh_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;

  always_comb begin
    dbl = {req_i, req_i};
    // rot[i] is requester (ptr+i) mod N
    rot = dbl[ptr_i +: N];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
  end

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    oh_o  = '0;
    if (any_o) begin
      idx_o = off + ptr_i;
      oh_o  = N'(1) << idx_o;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered grant,
// owner release, hold timeout and a mandatory dead cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  state_e            state_q;
  logic [IDXW-1:0]   ptr_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [N-1:0]      gnt_q;
  logic [IDXW-1:0]   idx_q;
  logic              valid_q;
  logic              tmo_q;

  logic [N-1:0]    pick_oh;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            owner_req;
  logic            expire;
  logic            release_d;
  logic            tmo_d;

  rr_pick u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .oh_o  (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    owner_req = req[idx_q];
    expire    = (MAX_HOLD != 0) &&
                (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    release_d = done || !owner_req || expire;
    // A timeout is only flagged when nothing else released the owner
    tmo_d     = expire && !done && owner_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q      <= pick_oh;
            idx_q      <= pick_idx;
            valid_q    <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (release_d) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + IDXW'(1);
            tmo_q   <= tmo_d;
            state_q <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, release paths,
// round-robin order, hold timeout and ignored done.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int pass_cnt;
  int total_cnt;

  rr_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt))
        else $error("FAIL inv_onehot gnt=%h", gnt);
      assert (gnt_idx == enc(gnt))
        else $error("FAIL inv_idx idx=%0d gnt=%h", gnt_idx, gnt);
      assert (gnt_valid == |gnt)
        else $error("FAIL inv_valid valid=%b gnt=%h", gnt_valid, gnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick();
    total_cnt++; if (gnt !== 8'h00) $display("FAIL rst_gnt got %h want 00", gnt); else pass_cnt++;
    total_cnt++; if (gnt_idx !== 3'd0) $display("FAIL rst_idx got %0d want 0", gnt_idx); else pass_cnt++;
    total_cnt++; if (gnt_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", gnt_valid); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL rst_tmo got %b want 0", timeout); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_done();
    req = 8'h01;
    tick();
    total_cnt++; if (gnt !== 8'h01) $display("FAIL t2_c1_gnt got %h want 01", gnt); else pass_cnt++;
    total_cnt++; if (gnt_idx !== 3'd0) $display("FAIL t2_c1_idx got %0d want 0", gnt_idx); else pass_cnt++;
    tick();
    total_cnt++; if (gnt !== 8'h01) $display("FAIL t2_c2_gnt got %h want 01", gnt); else pass_cnt++;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total_cnt++; if (gnt !== 8'h00) $display("FAIL t2_dead_gnt got %h want 00", gnt); else pass_cnt++;
    total_cnt++; if (gnt_valid !== 1'b0) $display("FAIL t2_dead_valid got %b want 0", gnt_valid); else pass_cnt++;
    tick();
    total_cnt++; if (gnt !== 8'h00) $display("FAIL t2_idle_gnt got %h want 00", gnt); else pass_cnt++;
    tick();
    total_cnt++; if (gnt !== 8'h01) $display("FAIL t2_regrant got %h want 01", gnt); else pass_cnt++;
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req  = 8'hFF;
    done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      total_cnt++; if (gnt_idx !== 3'(k % 8) || gnt !== 8'(1 << (k % 8)))
        $display("FAIL t3_grant%0d got idx %0d gnt %h want idx %0d", k, gnt_idx, gnt, k % 8); else pass_cnt++;
      tick();
      total_cnt++; if (gnt !== 8'h00) $display("FAIL t3_dead%0d got %h want 00", k, gnt); else pass_cnt++;
      tick();
    end
    req  = 8'h00;
    done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h80;
    tick();
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (gnt !== 8'h80 || timeout !== 1'b0)
        $display("FAIL t4_hold%0d got gnt %h tmo %b want 80/0", i, gnt, timeout); else pass_cnt++;
      tick();
    end
    total_cnt++; if (gnt !== 8'h00) $display("FAIL t4_revoke_gnt got %h want 00", gnt); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b1) $display("FAIL t4_tmo_pulse got %b want 1", timeout); else pass_cnt++;
    tick();
    total_cnt++; if (timeout !== 1'b0) $display("FAIL t4_tmo_end got %b want 0", timeout); else pass_cnt++;
    tick();
    total_cnt++; if (gnt_idx !== 3'd7 || gnt !== 8'h80)
      $display("FAIL t4_regrant got idx %0d gnt %h want 7/80", gnt_idx, gnt); else pass_cnt++;
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
  endtask

  task automatic test_owner_drop();
    req = 8'h20;
    tick();
    total_cnt++; if (gnt_idx !== 3'd5) $display("FAIL t5_grant got %0d want 5", gnt_idx); else pass_cnt++;
    req = 8'h00;
    tick();
    total_cnt++; if (gnt !== 8'h00 || timeout !== 1'b0)
      $display("FAIL t5_drop got gnt %h tmo %b want 00/0", gnt, timeout); else pass_cnt++;
    tick();
    req = 8'h21;
    tick();
    total_cnt++; if (gnt_idx !== 3'd0 || gnt !== 8'h01)
      $display("FAIL t5_wrap got idx %0d gnt %h want 0/01", gnt_idx, gnt); else pass_cnt++;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    total_cnt++; if (gnt_idx !== 3'd5 || gnt !== 8'h20)
      $display("FAIL t5_next got idx %0d gnt %h want 5/20", gnt_idx, gnt); else pass_cnt++;
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_done_ignored();
    done = 1'b1;
    tick();
    total_cnt++; if (gnt !== 8'h00 || timeout !== 1'b0 || gnt_valid !== 1'b0)
      $display("FAIL t6_idle_done got gnt %h tmo %b", gnt, timeout); else pass_cnt++;
    done = 1'b0;
    req  = 8'h08;
    tick();
    for (int i = 0; i < 15; i++) tick();
    total_cnt++; if (gnt !== 8'h08) $display("FAIL t6_c16 got %h want 08", gnt); else pass_cnt++;
    done = 1'b1;
    tick();
    done = 1'b0;
    total_cnt++; if (gnt !== 8'h00 || timeout !== 1'b0)
      $display("FAIL t6_done_expiry got gnt %h tmo %b want 00/0", gnt, timeout); else pass_cnt++;
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h04;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    total_cnt++; if (gnt !== 8'h04) $display("FAIL t1_regrant got %h want 04", gnt); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (gnt !== 8'h00 || gnt_idx !== 3'd0 || timeout !== 1'b0 || gnt_valid !== 1'b0)
      $display("FAIL t1_async got gnt %h idx %0d tmo %b", gnt, gnt_idx, timeout); else pass_cnt++;
    tick();
    rst = 1'b0;
    req = 8'h14;
    tick();
    total_cnt++; if (gnt_idx !== 3'd2) $display("FAIL t1_ptr_cleared got idx %0d want 2", gnt_idx); else pass_cnt++;
    req = 8'h00;
    tick();
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    test_reset();
    test_single_done();
    test_round_robin();
    test_timeout();
    test_owner_drop();
    test_done_ignored();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
